// File: rtl/bram_rr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bram_ctrl_pkg
//  Purpose  : Shared types and constants for the round-robin BRAM controller.
//  Revision : 1.0
// ============================================================================
package bram_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    localparam int C_ADDR_W_DEF = 6;
    localparam int C_DATA_W_DEF = 1;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_rr_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : bram_rr_ctrl_if
//  Purpose  : One requester's access channel into the shared BRAM controller.
//  Revision : 1.0
// ============================================================================
interface bram_rr_ctrl_if
    import bram_ctrl_pkg::*;
#(
    parameter int ADDR_W = C_ADDR_W_DEF,
    parameter int DATA_W = C_DATA_W_DEF
);
    logic              req;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, wr, addr, din, input gnt, rvalid, rdata);
    modport slave  (input req, wr, addr, din, output gnt, rvalid, rdata);
endinterface
`default_nettype wire

// File: rtl/bram_rr_ctrl_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-way round-robin arbiter with combinational one-hot grant.
//  Revision : 1.0
// ============================================================================
module rr_arb2 (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [1:0] req,
    input  wire logic       advance,
    output logic      [1:0] gnt
);
    logic r_prefer_b;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = r_prefer_b ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // After A wins, B is preferred next time, and vice versa
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prefer_b <= 1'b0;
        end else if (advance && (gnt != 2'b00)) begin
            r_prefer_b <= gnt[0];
        end
    end
endmodule
`default_nettype wire

// File: rtl/bram_rr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bram_rr_ctrl
//  Purpose  : Clears a simple dual-port BRAM after reset, then shares it
//             round-robin between two requesters, one operation per cycle.
//  Revision : 1.0
// ============================================================================
module bram_rr_ctrl
    import bram_ctrl_pkg::*;
#(
    parameter int                ADDR_W    = C_ADDR_W_DEF,
    parameter int                DATA_W    = C_DATA_W_DEF,
    parameter int                CLEAR_EN  = 1,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  wire logic              clk,
    input  wire logic              rst,
    output logic                   ready,
    bram_rr_ctrl_if.slave          a,
    bram_rr_ctrl_if.slave          b,
    output logic      [ADDR_W-1:0] wraddr,
    output logic                   wren,
    output logic                   we,
    output logic      [DATA_W-1:0] di,
    output logic      [ADDR_W-1:0] rdaddr,
    output logic                   rden,
    input  wire logic [DATA_W-1:0] dout,
    output logic                   regce,
    output logic                   bram_rst
);
    localparam int                c_depth = depth_of(ADDR_W);
    localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(c_depth - 1);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
    logic              r_tag;
    logic              r_rvalid;

    logic              w_run;
    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic              w_owner;
    logic              w_sel_wr;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_din;

    // Reset masks arbitration combinationally, not only from the next edge
    assign w_run = (r_state == ST_RUN) && !rst;
    assign w_req = {b.req, a.req} & {2{w_run}};

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (w_req),
        .advance (w_run),
        .gnt     (w_gnt)
    );

    assign a.gnt      = w_gnt[REQ_A];
    assign b.gnt      = w_gnt[REQ_B];
    assign w_owner    = w_gnt[REQ_B] ? REQ_B : REQ_A;
    assign w_sel_wr   = (w_owner == REQ_B) ? b.wr   : a.wr;
    assign w_sel_addr = (w_owner == REQ_B) ? b.addr : a.addr;
    assign w_sel_din  = (w_owner == REQ_B) ? b.din  : a.din;

    always_comb begin
        wren   = 1'b0;
        rden   = 1'b0;
        wraddr = '0;
        rdaddr = '0;
        di     = '0;
        if (!rst && (r_state == ST_INIT) && (CLEAR_EN != 0)) begin
            wren   = 1'b1;
            wraddr = r_cnt;
            di     = CLEAR_VAL;
        end else if (w_gnt != 2'b00) begin
            if (w_sel_wr) begin
                wren   = 1'b1;
                wraddr = w_sel_addr;
                di     = w_sel_din;
            end else begin
                rden   = 1'b1;
                rdaddr = w_sel_addr;
            end
        end
    end

    assign we       = wren;
    assign regce    = 1'b0;
    assign bram_rst = rst;
    assign ready    = (r_state == ST_RUN);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_INIT: begin
                if (CLEAR_EN != 0) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        w_state_nxt = ST_RUN;
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_INIT;
            r_cnt    <= '0;
            r_tag    <= REQ_A;
            r_rvalid <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_tag    <= w_owner;
            r_rvalid <= rden;
        end
    end

    // A read whose data returns during reset is dropped
    assign a.rvalid = r_rvalid && !rst && (r_tag == REQ_A);
    assign b.rvalid = r_rvalid && !rst && (r_tag == REQ_B);
    assign a.rdata  = dout;
    assign b.rdata  = dout;
endmodule
`default_nettype wire

// File: tb/tb_bram_rr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bram_rr_ctrl
//  Purpose  : Directed self-checking bench for bram_rr_ctrl with a BRAM model.
//  Revision : 1.0
// ============================================================================
module tb_bram_rr_ctrl;
    logic clk = 1'b0;
    logic rst, rst1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    bram_rr_ctrl_if #(.ADDR_W(6), .DATA_W(1)) a0 ();
    bram_rr_ctrl_if #(.ADDR_W(6), .DATA_W(1)) b0 ();
    bram_rr_ctrl_if #(.ADDR_W(6), .DATA_W(1)) a1 ();
    bram_rr_ctrl_if #(.ADDR_W(6), .DATA_W(1)) b1 ();

    logic       ready0, wren0, we0, rden0, regce0, brst0, di0, dout0;
    logic [5:0] wraddr0, rdaddr0;
    logic       ready1, wren1, we1, rden1, regce1, brst1, di1, dout1;
    logic [5:0] wraddr1, rdaddr1;
    logic       mem0 [64];
    logic       mem1 [64];

    bram_rr_ctrl #(.ADDR_W(6), .DATA_W(1), .CLEAR_EN(1), .CLEAR_VAL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .ready(ready0), .a(a0), .b(b0),
        .wraddr(wraddr0), .wren(wren0), .we(we0), .di(di0),
        .rdaddr(rdaddr0), .rden(rden0), .dout(dout0),
        .regce(regce0), .bram_rst(brst0)
    );

    bram_rr_ctrl #(.ADDR_W(6), .DATA_W(1), .CLEAR_EN(0), .CLEAR_VAL(1'b0)) dut1 (
        .clk(clk), .rst(rst1), .ready(ready1), .a(a1), .b(b1),
        .wraddr(wraddr1), .wren(wren1), .we(we1), .di(di1),
        .rdaddr(rdaddr1), .rden(rden1), .dout(dout1),
        .regce(regce1), .bram_rst(brst1)
    );

    // Behavioural BRAM_SDP_MACRO, DO_REG=0: one-cycle synchronous read
    always @(posedge clk) begin
        if (wren0) mem0[wraddr0] <= di0;
        if (rden0) dout0 <= mem0[rdaddr0];
        if (wren1) mem1[wraddr1] <= di1;
        if (rden1) dout1 <= mem1[rdaddr1];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Entered in the first cycle after reset release
    task automatic sweep0();
        for (int i = 0; i < 64; i++) begin
            chk("sweep_wren",  32'(wren0), 32'd1);
            chk("sweep_we",    32'(we0), 32'd1);
            chk("sweep_addr",  32'(wraddr0), 32'(i));
            chk("sweep_di",    32'(di0), 32'd0);
            chk("sweep_gnt",   32'({b0.gnt, a0.gnt}), 32'd0);
            chk("sweep_ready", 32'(ready0), 32'd0);
            step();
        end
        chk("ready_after_sweep", 32'(ready0), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem0[i] = 1'b1;
            mem1[i] = 1'b0;
        end
        rst = 1'b1; rst1 = 1'b1;
        a0.req = 1'b1; a0.wr = 1'b0; a0.addr = 6'd3; a0.din = 1'b0;
        b0.req = 1'b1; b0.wr = 1'b0; b0.addr = 6'd4; b0.din = 1'b0;
        a1.req = 1'b0; a1.wr = 1'b0; a1.addr = 6'd0; a1.din = 1'b0;
        b1.req = 1'b0; b1.wr = 1'b0; b1.addr = 6'd0; b1.din = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt",    32'({b0.gnt, a0.gnt}), 32'd0);
        chk("rst_wren",   32'(wren0), 32'd0);
        chk("rst_rden",   32'(rden0), 32'd0);
        chk("rst_ready",  32'(ready0), 32'd0);
        chk("rst_rvalid", 32'({b0.rvalid, a0.rvalid}), 32'd0);
        chk("bram_rst",   32'(brst0), 32'd1);
        chk("regce",      32'(regce0), 32'd0);

        @(negedge clk); rst = 1'b0; #1;
        sweep0();

        // Both requesters hold reads of 3 and 4: A, B, A, B
        chk("rr0_gnt",    32'({b0.gnt, a0.gnt}), 32'b01);
        chk("rr0_rden",   32'(rden0), 32'd1);
        chk("rr0_rdaddr", 32'(rdaddr0), 32'd3);
        chk("rr0_wren",   32'(wren0), 32'd0);
        step();
        chk("rr1_gnt",    32'({b0.gnt, a0.gnt}), 32'b10);
        chk("rr1_rdaddr", 32'(rdaddr0), 32'd4);
        chk("rr1_rvalid", 32'({b0.rvalid, a0.rvalid}), 32'b01);
        chk("rr1_rdata",  32'(a0.rdata), 32'd0);
        step();
        chk("rr2_gnt",    32'({b0.gnt, a0.gnt}), 32'b01);
        chk("rr2_rvalid", 32'({b0.rvalid, a0.rvalid}), 32'b10);
        chk("rr2_rdata",  32'(b0.rdata), 32'd0);
        step();
        chk("rr3_gnt",    32'({b0.gnt, a0.gnt}), 32'b10);
        chk("rr3_rvalid", 32'({b0.rvalid, a0.rvalid}), 32'b01);
        @(negedge clk); a0.req = 1'b0; b0.req = 1'b0; #1;
        chk("rr4_rvalid", 32'({b0.rvalid, a0.rvalid}), 32'b10);
        chk("idle_en",    32'({wren0, rden0}), 32'd0);

        // A writes 1 to 5, then reads it back
        @(negedge clk); a0.req = 1'b1; a0.wr = 1'b1; a0.addr = 6'd5; a0.din = 1'b1; #1;
        chk("wr5_gnt",    32'(a0.gnt), 32'd1);
        chk("wr5_wren",   32'({wren0, we0}), 32'b11);
        chk("wr5_addr",   32'(wraddr0), 32'd5);
        chk("wr5_di",     32'(di0), 32'd1);
        chk("wr5_rden",   32'(rden0), 32'd0);
        @(negedge clk); a0.wr = 1'b0; #1;
        chk("rd5_gnt",    32'(a0.gnt), 32'd1);
        chk("rd5_rden",   32'(rden0), 32'd1);
        chk("rd5_rdaddr", 32'(rdaddr0), 32'd5);
        chk("rd5_rvalid_early", 32'(a0.rvalid), 32'd0);
        @(negedge clk); a0.req = 1'b0; #1;
        chk("rd5_rvalid", 32'({b0.rvalid, a0.rvalid}), 32'b01);
        chk("rd5_rdata",  32'(a0.rdata), 32'd1);

        // B writes 1 to 20, leaving the pointer favouring A
        @(negedge clk); b0.req = 1'b1; b0.wr = 1'b1; b0.addr = 6'd20; b0.din = 1'b1; #1;
        chk("wr20_gnt",   32'({b0.gnt, a0.gnt}), 32'b10);
        chk("wr20_addr",  32'(wraddr0), 32'd20);

        // A writes 10 while B reads 10 in the same cycle
        @(negedge clk);
        b0.wr = 1'b0; b0.addr = 6'd10;
        a0.req = 1'b1; a0.wr = 1'b1; a0.addr = 6'd10; a0.din = 1'b1;
        #1;
        chk("col_gnt0",   32'({b0.gnt, a0.gnt}), 32'b01);
        chk("col_wraddr", 32'(wraddr0), 32'd10);
        @(negedge clk); a0.req = 1'b0; #1;
        chk("col_gnt1",   32'({b0.gnt, a0.gnt}), 32'b10);
        chk("col_rdaddr", 32'(rdaddr0), 32'd10);
        @(negedge clk); b0.req = 1'b0; #1;
        chk("col_rvalid", 32'({b0.rvalid, a0.rvalid}), 32'b10);
        chk("col_rdata",  32'(b0.rdata), 32'd1);

        // Reset arrives the cycle after a read grant
        @(negedge clk); a0.req = 1'b1; a0.wr = 1'b0; a0.addr = 6'd20; #1;
        chk("rr_rd_gnt",  32'({rden0, a0.gnt}), 32'b11);
        @(negedge clk); a0.req = 1'b0; rst = 1'b1; #1;
        chk("rst_mid_rvalid", 32'({b0.rvalid, a0.rvalid}), 32'd0);
        chk("rst_mid_wren",   32'(wren0), 32'd0);
        @(negedge clk); rst = 1'b0; #1;
        chk("rst_mid_ready",  32'(ready0), 32'd0);
        sweep0();
        @(negedge clk); a0.req = 1'b1; a0.wr = 1'b0; a0.addr = 6'd20; #1;
        chk("clr20_gnt",  32'(a0.gnt), 32'd1);
        @(negedge clk); a0.req = 1'b0; #1;
        chk("clr20_rvalid", 32'(a0.rvalid), 32'd1);
        chk("clr20_rdata",  32'(a0.rdata), 32'd0);

        // CLEAR_EN=0 instance: one idle cycle, no sweep, memory retained
        a1.req = 1'b1; a1.wr = 1'b1; a1.addr = 6'd5; a1.din = 1'b1;
        @(negedge clk); rst1 = 1'b0; #1;
        chk("nc_init_ready", 32'(ready1), 32'd0);
        chk("nc_init_wren",  32'(wren1), 32'd0);
        chk("nc_init_gnt",   32'(a1.gnt), 32'd0);
        step();
        chk("nc_run_ready",  32'(ready1), 32'd1);
        chk("nc_wr_gnt",     32'({wren1, a1.gnt}), 32'b11);
        chk("nc_wr_addr",    32'(wraddr1), 32'd5);
        @(negedge clk); a1.req = 1'b0; rst1 = 1'b1; #1;
        chk("nc_rst_wren",   32'(wren1), 32'd0);
        @(negedge clk); rst1 = 1'b0; #1;
        chk("nc_rst2_ready", 32'(ready1), 32'd0);
        chk("nc_rst2_wren",  32'(wren1), 32'd0);
        step();
        chk("nc_rst2_run",   32'(ready1), 32'd1);
        @(negedge clk); a1.req = 1'b1; a1.wr = 1'b0; a1.addr = 6'd5; #1;
        chk("nc_rd_en",      32'({rden1, a1.gnt}), 32'b11);
        @(negedge clk); a1.req = 1'b0; #1;
        chk("nc_rd_rvalid",  32'(a1.rvalid), 32'd1);
        chk("nc_rd_rdata",   32'(a1.rdata), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
